// File: rtl/dct_row_sched_if.sv
// Handshake and datapath bundle between the row-DCT sequencer, its upstream source,
// the external row-DCT datapath and the downstream column stage.
interface dct_row_sched_if #(
    parameter int ROWS = 8,
    parameter int CW   = 9
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*8-1:0]    in_row;
    logic [ROWS*8-1:0]    dct_in;
    logic [ROWS*CW-1:0]   dct_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [ROWS*CW-1:0]   out_col;
    logic                 out_last;

    modport master (
        output in_valid, in_row, dct_out, out_ready,
        input  in_ready, dct_in, out_valid, out_col, out_last
    );

    modport slave (
        input  in_valid, in_row, dct_out, out_ready,
        output in_ready, dct_in, out_valid, out_col, out_last
    );
endinterface

// File: rtl/dct_row_sched.sv
// Row-DCT sequencer: captures eight row-DCT results into a transpose buffer, then
// streams the block out column by column.
module dct_row_sched #(
    parameter int ROWS  = 8,
    parameter int CW    = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    dct_row_sched_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] blocks_done
);
    localparam int IDX_W = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    typedef enum logic [0:0] {StLoad, StDrain} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] row_cnt_q, row_cnt_d;
    logic [IDX_W-1:0] col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0] blocks_done_q, blocks_done_d;
    logic [CW-1:0]    buf_q [ROWS][ROWS];
    logic             load_fire;

    // The row DCT is purely combinational, so its result is valid in the accept cycle.
    assign bus.dct_in  = bus.in_row;
    assign load_fire   = bus.in_valid && (state_q == StLoad);
    assign busy        = (state_q == StDrain) || (row_cnt_q != '0);
    assign blocks_done = blocks_done_q;
    assign bus.out_last = (state_q == StDrain) && (col_cnt_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        col_cnt_d     = col_cnt_q;
        blocks_done_d = blocks_done_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            StLoad: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == LAST_IDX) begin
                        row_cnt_d = '0;
                        state_d   = StDrain;
                    end
                end
            end
            StDrain: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    col_cnt_d = col_cnt_q + 1'b1;
                    if (col_cnt_q == LAST_IDX) begin
                        col_cnt_d     = '0;
                        blocks_done_d = blocks_done_q + 1'b1;
                        state_d       = StLoad;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StLoad;
            row_cnt_q     <= '0;
            col_cnt_q     <= '0;
            blocks_done_q <= '0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            col_cnt_q     <= col_cnt_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    // Buffer has no reset: every entry is rewritten during LOAD before DRAIN reads it.
    always_ff @(posedge clk) begin
        if (load_fire && !rst) begin
            for (int k = 0; k < ROWS; k++) begin
                buf_q[row_cnt_q][k] <= bus.dct_out[(ROWS-k)*CW-1 -: CW];
            end
        end
    end

    always_comb begin
        bus.out_col = '0;
        for (int r = 0; r < ROWS; r++) begin
            bus.out_col[(ROWS-r)*CW-1 -: CW] = buf_q[r][col_cnt_q];
        end
    end
endmodule

// File: doc/dct_row_sched.md
# dct_row_sched

Sequencer for the combinational 8-point row DCT stage of the JPEG encoder. It accepts one 8x8 pixel block row by row over a valid/ready handshake and drives each row into the external row-DCT datapath. It captures the eight 9-bit coefficients per row into an internal 8x8 transpose buffer, then streams the block out column by column to the column-DCT stage over a second valid/ready handshake.

## Interface
Parameters:
- ROWS, 8, rows and columns per block; fixed at 8, not user-tunable.
- CW, 9, coefficient width as delivered by the row DCT.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  block can accept a row.
- in_row  in  64  eight unsigned 8-bit pixels; pixel 0 in [63:56], pixel 7 in [7:0].
- dct_in  out  64  to row-DCT input.
- dct_out  in  72  from row-DCT output. Coefficient k is in [71-9k -: 9].
- out_valid  out  1  column available.
- out_ready  in  1  downstream accepts column.
- out_col  out  72  column j = {row0 coef j, row1 coef j, …, row7 coef j}; row 0 in [71:63].
- out_last  out  1  high with column 7 of a block.
- busy  out  1  high in DRAIN, or in LOAD with row count > 0.
- blocks_done  out  CNT_W  completed blocks since reset; wraps modulo 2^CNT_W.

## Operation
- States: LOAD (accept rows) and DRAIN (emit columns). There is a single buffer and no overlap between states.
- LOAD:
  - in_ready = 1, out_valid = 0.
  - dct_in = in_row, passed through combinationally because the row DCT has zero latency.
  - On each in_valid & in_ready edge, write dct_out into buffer row row_cnt and increment row_cnt.
  - When the handshake occurs with row_cnt = 7: set row_cnt to 0 and go to DRAIN.
- DRAIN:
  - in_ready = 0, out_valid = 1.
  - out_col is assembled combinationally from buffer column col_cnt.
  - out_last = (col_cnt = 7).
  - On each out_valid & out_ready edge, increment col_cnt.
  - When the handshake occurs with col_cnt = 7: set col_cnt to 0, increment blocks_done, and go to LOAD.
- dct_in in DRAIN: holds in_row, so it is a don't-care. Nothing is captured.
- in_valid while in_ready = 0 is ignored. The upstream must hold the row stable until it is accepted.
- out_col and out_last must stay stable while out_valid = 1 and out_ready = 0.
- The buffer is not cleared at reset or between blocks. Every entry is overwritten before it is read.

## Timing
- Reset values, in the cycle after the rst edge: state = LOAD, row_cnt = 0, col_cnt = 0, in_ready = 1, out_valid = 0, out_last = 0, busy = 0, blocks_done = 0.
- Reset in mid-operation (LOAD or DRAIN): abandon the partial block. No column of it is emitted afterward, and blocks_done is not incremented.
- Capture latency: 0 cycles. The row accepted at edge t is in the buffer from t+1.
- out_valid first rises the cycle after the 8th row handshake.
- in_ready rises the cycle after the out_last handshake.
- Minimum block period: 16 cycles (8 LOAD + 8 DRAIN) with in_valid and out_ready held high.
- Stalls: in_valid low stalls LOAD and out_ready low stalls DRAIN, each with no state change.
- rst takes priority over any simultaneous handshake.

## Test plan
- All pixels 128 (in_row = 64'h8080808080808080) for 8 rows, out_ready = 1. Required response:
  - column 0 = 72'h2D_16_8B_45_A2_D1_68_B4_5A, i.e. eight 9'd90.
  - columns 1–7 = 0.
  - out_last only on column 7; blocks_done = 1.
- Row r filled with value 16r (r = 0..7). Column 0, row 0 to row 7, must equal 9'd0, 11, 22, 33, 45, 56, 67, 78. This checks transpose order.
- Block from test 1 with out_ready low for 5 cycles at column 3:
  - out_col holds column 3 and out_valid stays 1.
  - in_ready = 0 throughout; col_cnt unchanged.
  - Column 3 is emitted exactly once after release.
- in_valid toggled 1,0,0,1,… with pixels changed during the low cycles: only the handshaked rows are captured. The result matches test 1.
- rst asserted for 1 cycle at column 4 of DRAIN. The next cycle shows out_valid = 0, in_ready = 1, busy = 0, blocks_done = 0, and no remaining columns are emitted. A fresh block then completes normally.
- 3 back-to-back blocks with in_valid and out_ready held high:
  - the first out_valid is at cycle 8 after the first accept;
  - out_last pulses at cycles 15, 31 and 47;
  - blocks_done = 3.
